// File: rtl/ami_spi_responder_pkg.sv
// rtl/ami_spi_responder_pkg.sv - shared constants and state encoding for the SPI responder
package ami_spi_pkg;

  localparam int CMD_WIDTH = 8;
  localparam int RW_BIT    = 7;

  typedef enum logic [2:0] {
    ST_WAIT_CSB_HIGH = 3'd0,
    ST_IDLE          = 3'd1,
    ST_CMD           = 3'd2,
    ST_DATA_WR       = 3'd3,
    ST_DATA_RD       = 3'd4,
    ST_OVERRUN       = 3'd5
  } state_t;

  function automatic logic in_frame(input state_t s);
    return (s == ST_CMD) || (s == ST_DATA_WR) || (s == ST_DATA_RD) || (s == ST_OVERRUN);
  endfunction

endpackage

// File: rtl/ami_spi_responder_if.sv
// rtl/ami_spi_responder_if.sv - SPI pins and register-file port bundle
interface ami_spi_responder_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 7
);
  logic                  spiCsb;
  logic                  spiSclk;
  logic                  spiMosi;
  logic                  spiMiso;
  logic                  spiMisoOe;
  logic                  rdReq;
  logic [ADDR_WIDTH-1:0] rdAddr;
  logic [DATA_WIDTH-1:0] rdData;
  logic                  wrStrobe;
  logic [ADDR_WIDTH-1:0] wrAddr;
  logic [DATA_WIDTH-1:0] wrData;
  logic                  frameErr;
  logic                  busy;

  modport slave (
    input  spiCsb, spiSclk, spiMosi, rdData,
    output spiMiso, spiMisoOe, rdReq, rdAddr, wrStrobe, wrAddr, wrData, frameErr, busy
  );

  modport master (
    output spiCsb, spiSclk, spiMosi, rdData,
    input  spiMiso, spiMisoOe, rdReq, rdAddr, wrStrobe, wrAddr, wrData, frameErr, busy
  );
endinterface

// File: rtl/ami_spi_responder_edge_sync.sv
// rtl/ami_spi_responder_edge_sync.sv - 2-flop synchronizer with registered rise/fall pulses
module spi_edge_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);
  // Flops reset low so a line already high at reset release yields a rise pulse.
  logic [2:0] r_sh;
  logic       r_rise;
  logic       r_fall;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sh   <= '0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sh   <= {r_sh[1:0], i_async};
      r_rise <= r_sh[1] & ~r_sh[2];
      r_fall <= ~r_sh[1] & r_sh[2];
    end
  end

  assign o_rise = r_rise;
  assign o_fall = r_fall;
endmodule

// File: rtl/ami_spi_responder.sv
// rtl/ami_spi_responder.sv - mode-0 SPI responder turning command frames into register strobes
module ami_spi_responder
  import ami_spi_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 7
) (
  input logic           sysClk,
  input logic           sysReset_n,
  ami_spi_responder_if.slave bus
);
  localparam int FRAME_BITS = CMD_WIDTH + DATA_WIDTH;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_CMD_LAST   = CNT_W'(CMD_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_FRAME_LAST = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_FRAME_FULL = CNT_W'(FRAME_BITS);

  state_t                r_state, w_state_nxt;
  logic                  w_csb_rise, w_csb_fall, w_sclk_rise, w_sclk_fall;
  logic [2:0]            r_mosi_sync;
  logic                  w_mosi;
  logic [CNT_W-1:0]      r_cnt, w_cnt_eff;
  logic [DATA_WIDTH-1:0] r_rx, r_tx, r_wr_data;
  logic [ADDR_WIDTH-1:0] r_addr, r_rd_addr, r_wr_addr;
  logic                  r_rd_req, r_rd_cap, r_wr_strobe, r_miso, r_oe;
  logic                  w_counting, w_last_cmd, w_last_data, w_frame_err, w_busy;
  logic [CMD_WIDTH-1:0]  w_cmd_byte;

  spi_edge_sync u_csb_sync (
    .i_clk   (sysClk),
    .i_rst_n (sysReset_n),
    .i_async (bus.spiCsb),
    .o_rise  (w_csb_rise),
    .o_fall  (w_csb_fall)
  );

  spi_edge_sync u_sclk_sync (
    .i_clk   (sysClk),
    .i_rst_n (sysReset_n),
    .i_async (bus.spiSclk),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall)
  );

  // Three stages so MOSI lines up with the registered SCLK edge pulse.
  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) r_mosi_sync <= '0;
    else             r_mosi_sync <= {r_mosi_sync[1:0], bus.spiMosi};
  end

  assign w_mosi      = r_mosi_sync[2];
  assign w_counting  = (r_state == ST_CMD) || (r_state == ST_DATA_WR) || (r_state == ST_DATA_RD);
  assign w_cnt_eff   = r_cnt + CNT_W'(w_counting && w_sclk_rise);
  assign w_cmd_byte  = {r_rx[CMD_WIDTH-2:0], w_mosi};
  assign w_last_cmd  = (r_state == ST_CMD) && w_sclk_rise && (r_cnt == CNT_CMD_LAST);
  assign w_last_data = ((r_state == ST_DATA_WR) || (r_state == ST_DATA_RD)) &&
                       w_sclk_rise && (r_cnt == CNT_FRAME_LAST);

  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) r_state <= ST_WAIT_CSB_HIGH;
    else             r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_frame_err = 1'b0;
    w_busy      = in_frame(r_state);
    case (r_state)
      ST_WAIT_CSB_HIGH: w_state_nxt = ST_WAIT_CSB_HIGH;
      ST_IDLE:          if (w_csb_fall) w_state_nxt = ST_CMD;
      ST_CMD:           if (w_last_cmd) w_state_nxt = w_cmd_byte[RW_BIT] ? ST_DATA_RD : ST_DATA_WR;
      ST_DATA_WR,
      ST_DATA_RD:       if (w_last_data) w_state_nxt = ST_OVERRUN;
      ST_OVERRUN:       w_state_nxt = ST_OVERRUN;
      default:          w_state_nxt = ST_WAIT_CSB_HIGH;
    endcase
    // A coincident final SCLK rise is already folded into w_cnt_eff.
    if (w_csb_rise) begin
      w_state_nxt = ST_IDLE;
      w_frame_err = in_frame(r_state) && (w_cnt_eff != '0) && (w_cnt_eff != CNT_FRAME_FULL);
    end
  end

  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) begin
      r_cnt       <= '0;
      r_rx        <= '0;
      r_tx        <= '0;
      r_addr      <= '0;
      r_rd_addr   <= '0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_rd_req    <= 1'b0;
      r_rd_cap    <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_miso      <= 1'b0;
      r_oe        <= 1'b0;
    end else begin
      r_rd_req    <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_rd_cap    <= r_rd_req;

      if ((r_state == ST_IDLE) && w_csb_fall) begin
        r_cnt <= '0;
      end else if (w_counting && w_sclk_rise) begin
        r_cnt <= r_cnt + 1'b1;
        r_rx  <= {r_rx[DATA_WIDTH-2:0], w_mosi};
      end

      if (w_last_cmd) begin
        r_addr <= w_cmd_byte[ADDR_WIDTH-1:0];
        if (w_cmd_byte[RW_BIT]) begin
          r_rd_addr <= w_cmd_byte[ADDR_WIDTH-1:0];
          r_rd_req  <= 1'b1;
          r_oe      <= 1'b1;
        end
      end

      if (w_last_data && (r_state == ST_DATA_WR)) begin
        r_wr_addr   <= r_addr;
        r_wr_data   <= {r_rx[DATA_WIDTH-2:0], w_mosi};
        r_wr_strobe <= 1'b1;
      end

      if (w_sclk_fall) begin
        if (r_state == ST_DATA_RD) begin
          r_miso <= r_tx[DATA_WIDTH-1];
          r_tx   <= {r_tx[DATA_WIDTH-2:0], 1'b0};
        end else begin
          r_miso <= 1'b0;
        end
      end

      if (r_rd_cap) r_tx <= bus.rdData;

      if (w_csb_rise) begin
        r_oe   <= 1'b0;
        r_miso <= 1'b0;
      end
    end
  end

  assign bus.spiMiso   = r_miso;
  assign bus.spiMisoOe = r_oe & ~w_csb_rise;
  assign bus.rdReq     = r_rd_req;
  assign bus.rdAddr    = r_rd_addr;
  assign bus.wrStrobe  = r_wr_strobe;
  assign bus.wrAddr    = r_wr_addr;
  assign bus.wrData    = r_wr_data;
  assign bus.frameErr  = w_frame_err;
  assign bus.busy      = w_busy;
endmodule

// File: tb/tb_ami_spi_responder.sv
// tb/tb_ami_spi_responder.sv - directed and random frames against the SPI responder
module tb_ami_spi_responder;
  localparam int DW = 16;
  localparam int AW = 7;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic sysClk = 1'b0;
  logic sysReset_n = 1'b0;
  always #5 sysClk = ~sysClk;

  ami_spi_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  ami_spi_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .sysClk     (sysClk),
    .sysReset_n (sysReset_n),
    .bus        (bus)
  );

  int checks = 0;
  int failures = 0;
  int n_rdreq = 0;
  int n_ferr = 0;
  logic [AW-1:0] last_rd_addr = '0;
  wr_t wr_q[$];
  logic [DW-1:0] rd_q[$];
  logic [DW-1:0] mem[0:127];
  logic [DW-1:0] model[0:127];
  logic pre_we = 1'b0;
  logic [AW-1:0] pre_a = '0;
  logic [DW-1:0] pre_d = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Register file behind the responder: synchronous read, written by wrStrobe.
  always @(posedge sysClk) begin
    if (pre_we) mem[pre_a] <= pre_d;
    else if (bus.wrStrobe) mem[bus.wrAddr] <= bus.wrData;
    if (bus.rdReq) bus.rdData <= mem[bus.rdAddr];
  end

  always @(negedge sysClk) begin
    if (sysReset_n) begin
      if (bus.rdReq) begin
        n_rdreq++;
        last_rd_addr = bus.rdAddr;
      end
      if (bus.frameErr) n_ferr++;
      if (bus.wrStrobe) begin
        if (wr_q.size() == 0) begin
          chk("wr_unexpected", 32'(bus.wrAddr), 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = wr_q.pop_front();
          chk("wr_addr", 32'(bus.wrAddr), 32'(e.a));
          chk("wr_data", 32'(bus.wrData), 32'(e.d));
        end
      end
    end
  end

  task automatic spi_bits(input logic [23:0] fr, input int first, input int last, input int half);
    for (int i = first; i < last; i++) begin
      bus.spiMosi = fr[23-i];
      repeat (half) @(negedge sysClk);
      bus.spiSclk = 1'b1;
      repeat (half) @(negedge sysClk);
      bus.spiSclk = 1'b0;
    end
  endtask

  task automatic spi_frame(input logic [7:0] cmd, input logic [15:0] data, input int nedges,
                           input int half, input bit csb_with_last,
                           output logic [15:0] rx, output int oe_bad, output int miso_bad);
    logic [23:0] fr;
    logic rd;
    fr = {cmd, data};
    rd = cmd[7];
    rx = '0;
    oe_bad = 0;
    miso_bad = 0;
    bus.spiCsb = 1'b0;
    for (int i = 0; i < nedges; i++) begin
      bus.spiMosi = (i < 24) ? fr[23-i] : 1'b1;
      repeat (half) @(negedge sysClk);
      if (bus.spiMisoOe !== (rd && i >= 8)) oe_bad++;
      if (rd && i >= 8 && i < 24) rx = {rx[14:0], bus.spiMiso};
      else if (i >= 8 && bus.spiMiso !== 1'b0) miso_bad++;
      bus.spiSclk = 1'b1;
      if (csb_with_last && i == nedges - 1) bus.spiCsb = 1'b1;
      repeat (half) @(negedge sysClk);
      bus.spiSclk = 1'b0;
    end
    if (!csb_with_last) begin
      repeat (half) @(negedge sysClk);
      bus.spiCsb = 1'b1;
    end
    repeat (16) @(negedge sysClk);
  endtask

  initial begin
    logic [15:0] rx;
    int ob, mb, ob_sum, mb_sum, ferr0, rd0;
    logic [AW-1:0] a;
    logic [DW-1:0] d;

    bus.spiCsb = 1'b1;
    bus.spiSclk = 1'b0;
    bus.spiMosi = 1'b0;
    repeat (3) @(negedge sysClk);
    chk("reset_ctl", 32'({bus.spiMiso, bus.spiMisoOe, bus.rdReq, bus.wrStrobe, bus.frameErr, bus.busy}), 32'h0);
    chk("reset_addr", 32'({bus.rdAddr, bus.wrAddr}), 32'h0);
    chk("reset_wrdata", 32'(bus.wrData), 32'h0);
    sysReset_n = 1'b1;

    for (int k = 0; k < 128; k++) begin
      pre_we = 1'b1;
      pre_a = AW'(k);
      pre_d = (k == 3) ? 16'h1234 : DW'(k * 16'h0101) ^ 16'h5A5A;
      model[k] = pre_d;
      @(negedge sysClk);
    end
    pre_we = 1'b0;
    repeat (4) @(negedge sysClk);
    chk("idle_busy", 32'(bus.busy), 32'h0);

    // Write 0x05 <- 0xBEEF at sysClk/10
    ferr0 = n_ferr;
    wr_q.push_back('{7'h05, 16'hBEEF});
    model[5] = 16'hBEEF;
    spi_frame(8'h05, 16'hBEEF, 24, 5, 1'b0, rx, ob, mb);
    chk("t1_wr_seen", 32'(wr_q.size()), 32'h0);
    chk("t1_ferr", 32'(n_ferr - ferr0), 32'h0);
    chk("t1_oe", 32'(ob), 32'h0);
    chk("t1_miso", 32'(mb), 32'h0);

    // Read 0x03 -> 0x1234
    ferr0 = n_ferr;
    rd0 = n_rdreq;
    rd_q.push_back(model[3]);
    spi_frame(8'h83, 16'h0000, 24, 5, 1'b0, rx, ob, mb);
    chk("t2_rdreq_cnt", 32'(n_rdreq - rd0), 32'h1);
    chk("t2_rdaddr", 32'(last_rd_addr), 32'h03);
    chk("t2_rx", 32'(rx), 32'(rd_q.pop_front()));
    chk("t2_oe", 32'(ob), 32'h0);
    chk("t2_ferr", 32'(n_ferr - ferr0), 32'h0);

    // Aborted write after 12 edges, then a good frame
    ferr0 = n_ferr;
    spi_frame(8'h11, 16'hAAAA, 12, 5, 1'b0, rx, ob, mb);
    chk("t3_ferr", 32'(n_ferr - ferr0), 32'h1);
    chk("t3_busy", 32'(bus.busy), 32'h0);
    ferr0 = n_ferr;
    wr_q.push_back('{7'h11, 16'h4321});
    model[17] = 16'h4321;
    spi_frame(8'h11, 16'h4321, 24, 5, 1'b0, rx, ob, mb);
    spi_frame(8'h91, 16'h0000, 24, 5, 1'b0, rx, ob, mb);
    chk("t3_readback", 32'(rx), 32'h4321);
    chk("t3_ferr_after", 32'(n_ferr - ferr0), 32'h0);

    // Overrun frames: 30-edge write, 28-edge read
    ferr0 = n_ferr;
    wr_q.push_back('{7'h22, 16'h0F0F});
    model[34] = 16'h0F0F;
    spi_frame(8'h22, 16'h0F0F, 30, 5, 1'b0, rx, ob, mb);
    chk("t4_wr_seen", 32'(wr_q.size()), 32'h0);
    chk("t4_miso", 32'(mb), 32'h0);
    spi_frame(8'hA2, 16'h0000, 28, 5, 1'b0, rx, ob, mb);
    chk("t4_rd_rx", 32'(rx), 32'h0F0F);
    chk("t4_rd_miso_tail", 32'(mb), 32'h0);
    chk("t4_ferr", 32'(n_ferr - ferr0), 32'h0);

    // Reset in the middle of a write with CSB held low
    ferr0 = n_ferr;
    bus.spiCsb = 1'b0;
    repeat (4) @(negedge sysClk);
    spi_bits({8'h33, 16'hFFFF}, 0, 10, 4);
    sysReset_n = 1'b0;
    #1;
    chk("t5_rst_ctl", 32'({bus.spiMiso, bus.spiMisoOe, bus.rdReq, bus.wrStrobe, bus.frameErr, bus.busy}), 32'h0);
    chk("t5_rst_addr", 32'({bus.rdAddr, bus.wrAddr}), 32'h0);
    chk("t5_rst_wrdata", 32'(bus.wrData), 32'h0);
    repeat (3) @(negedge sysClk);
    sysReset_n = 1'b1;
    spi_bits({8'h33, 16'hFFFF}, 10, 24, 4);
    chk("t5_busy_ignored", 32'(bus.busy), 32'h0);
    repeat (4) @(negedge sysClk);
    bus.spiCsb = 1'b1;
    repeat (16) @(negedge sysClk);
    chk("t5_ferr", 32'(n_ferr - ferr0), 32'h0);
    wr_q.push_back('{7'h33, 16'h5555});
    model[51] = 16'h5555;
    spi_frame(8'h33, 16'h5555, 24, 4, 1'b0, rx, ob, mb);
    chk("t5_wr_seen", 32'(wr_q.size()), 32'h0);

    // CSB rise coincident with the final SCLK rise
    ferr0 = n_ferr;
    wr_q.push_back('{7'h44, 16'h9876});
    model[68] = 16'h9876;
    spi_frame(8'h44, 16'h9876, 24, 4, 1'b1, rx, ob, mb);
    chk("t6_wr_seen", 32'(wr_q.size()), 32'h0);
    chk("t6_ferr", 32'(n_ferr - ferr0), 32'h0);

    // Random read/write mix at sysClk/8
    ferr0 = n_ferr;
    ob_sum = 0;
    mb_sum = 0;
    for (int k = 0; k < 24; k++) begin
      a = AW'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        rd_q.push_back(model[a]);
        spi_frame({1'b1, a}, 16'h0000, 24, 4, 1'b0, rx, ob, mb);
        chk("rnd_rd", 32'(rx), 32'(rd_q.pop_front()));
      end else begin
        d = DW'($urandom);
        wr_q.push_back('{a, d});
        model[a] = d;
        spi_frame({1'b0, a}, d, 24, 4, 1'b0, rx, ob, mb);
      end
      ob_sum += ob;
      mb_sum += mb;
    end
    chk("rnd_oe", 32'(ob_sum), 32'h0);
    chk("rnd_miso", 32'(mb_sum), 32'h0);
    chk("rnd_ferr", 32'(n_ferr - ferr0), 32'h0);
    chk("final_wr_q", 32'(wr_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
